// File: rtl/out_display_seq_pkg.sv
// out_display_seq_pkg: shared FSM encoding, segment constants and digit table
package out_display_seq_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   localparam logic [6:0] DIGIT_SEG [10] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
   };

   function automatic logic [6:0] seg_pat(input logic [3:0] d);
      return (d > 4'd9) ? SEG_BLANK : DIGIT_SEG[d];
   endfunction

   function automatic logic [3:0] add3(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

endpackage

// File: rtl/out_display_seq_bcd_to_seg7.sv
// bcd_to_seg7: one BCD digit to a 7-segment pattern (gfedcba) with blank/dash override
module bcd_to_seg7
   import out_display_seq_pkg::*;
(
   input  logic [3:0] bcd,
   input  logic       blank,
   input  logic       dash,
   input  logic       active_low,
   output logic [6:0] seg
);

   logic [6:0] seg_al;

   // dash overrides blank, blank overrides the digit; the table is active-low
   always_comb begin
      seg_al = dash ? SEG_DASH : blank ? SEG_BLANK : seg_pat(bcd);
      seg    = active_low ? seg_al : ~seg_al;
   end

endmodule

// File: rtl/out_display_seq.sv
// out_display_seq: sequential binary-to-BCD conversion driving three 7-segment displays
module out_display_seq
   import out_display_seq_pkg::*;
#(
   parameter int DATA_W     = 9,
   parameter bit ACTIVE_LOW = 1,
   parameter bit LZB        = 0
) (
   input  logic              clk,
   input  logic              n_reset,
   input  logic              load,
   input  logic [DATA_W-1:0] data_in,
   input  logic              show,
   output logic              busy,
   output logic [11:0]       bcd_out,
   output logic [6:0]        Display1,
   output logic [6:0]        Display2,
   output logic [6:0]        Display3
);

   localparam int             CW        = $clog2(DATA_W + 1);
   localparam logic [CW-1:0]  CNT_END   = CW'(DATA_W);
   localparam logic [6:0]     BLANK_OUT = ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK;

   state_t            state, state_nx;
   logic [DATA_W-1:0] shreg, shreg_nx, pend_val, pend_val_nx;
   logic [11:0]       acc, acc_nx, adj;
   logic [CW-1:0]     cnt, cnt_nx;
   logic              pend, pend_nx;
   logic              valid;
   logic [6:0]        seg1, seg2, seg3;

   // next-state, shift/add-3 step and newest-wins pending slot
   always_comb begin
      state_nx    = state;
      shreg_nx    = shreg;
      acc_nx      = acc;
      cnt_nx      = cnt;
      pend_nx     = pend;
      pend_val_nx = pend_val;
      adj         = {add3(acc[11:8]), add3(acc[7:4]), add3(acc[3:0])};
      case (state)
         IDLE: if (load || pend) begin
            shreg_nx = load ? data_in : pend_val;
            acc_nx   = '0;
            cnt_nx   = '0;
            pend_nx  = 1'b0;
            state_nx = SHIFT;
         end
         SHIFT: begin
            {acc_nx, shreg_nx} = {adj, shreg} << 1;
            cnt_nx             = cnt + 1'b1;
            if (cnt_nx == CNT_END) state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (load && state != IDLE) begin
         pend_nx     = 1'b1;
         pend_val_nx = data_in;
      end
   end

   // FSM state, datapath and result registers; valid marks a first completed conversion
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state    <= IDLE;
         shreg    <= '0;
         acc      <= '0;
         cnt      <= '0;
         pend     <= 1'b0;
         pend_val <= '0;
         busy     <= 1'b0;
         bcd_out  <= '0;
         valid    <= 1'b0;
      end else begin
         state    <= state_nx;
         shreg    <= shreg_nx;
         acc      <= acc_nx;
         cnt      <= cnt_nx;
         pend     <= pend_nx;
         pend_val <= pend_val_nx;
         busy     <= (state_nx != IDLE) || pend_nx;
         if (state == DONE) begin
            bcd_out <= acc;
            valid   <= 1'b1;
         end
      end
   end

   bcd_to_seg7 u_units (
      .bcd        (bcd_out[3:0]),
      .blank      (!valid),
      .dash       (!show),
      .active_low (ACTIVE_LOW),
      .seg        (seg1)
   );

   bcd_to_seg7 u_tens (
      .bcd        (bcd_out[7:4]),
      .blank      (!valid || (LZB && bcd_out[11:4] == 8'h00)),
      .dash       (!show),
      .active_low (ACTIVE_LOW),
      .seg        (seg2)
   );

   bcd_to_seg7 u_hundreds (
      .bcd        (bcd_out[11:8]),
      .blank      (!valid || (LZB && bcd_out[11:8] == 4'h0)),
      .dash       (!show),
      .active_low (ACTIVE_LOW),
      .seg        (seg3)
   );

   // segment registers follow bcd_out/show every cycle so displays lag by one clock
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         Display1 <= BLANK_OUT;
         Display2 <= BLANK_OUT;
         Display3 <= BLANK_OUT;
      end else begin
         Display1 <= seg1;
         Display2 <= seg2;
         Display3 <= seg3;
      end
   end

endmodule

// File: tb/tb_out_display_seq.sv
// tb_out_display_seq: directed scoreboard bench for out_display_seq (LZB=0 and LZB=1 instances)
module tb_out_display_seq;

   logic       clk = 1'b0;
   logic       n_reset;
   logic       load;
   logic [8:0] data_in;
   logic       show;
   logic       busy, zbusy;
   logic [11:0] bcd, zbcd;
   logic [6:0] d1, d2, d3, z1, z2, z3;

   int total = 0;
   int fails = 0;
   int q[$];

   logic [6:0] pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   out_display_seq #(.DATA_W(9), .ACTIVE_LOW(1), .LZB(0)) dut (
      .clk(clk), .n_reset(n_reset), .load(load), .data_in(data_in), .show(show),
      .busy(busy), .bcd_out(bcd), .Display1(d1), .Display2(d2), .Display3(d3)
   );

   out_display_seq #(.DATA_W(9), .ACTIVE_LOW(1), .LZB(1)) dut_z (
      .clk(clk), .n_reset(n_reset), .load(load), .data_in(data_in), .show(show),
      .busy(zbusy), .bcd_out(zbcd), .Display1(z1), .Display2(z2), .Display3(z3)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [20:0] exp_disp(input int v, input bit lzb, input bit dash);
      logic [6:0] h, t, u;
      if (dash) return {3{7'h3F}};
      h = (lzb && v < 100) ? 7'h7F : pat[v / 100];
      t = (lzb && v < 10)  ? 7'h7F : pat[(v / 10) % 10];
      u = pat[v % 10];
      return {h, t, u};
   endfunction

   function automatic logic [11:0] exp_bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_idle(input string tag);
      chk({tag, " busy"}, 32'(busy), 32'(0));
      chk({tag, " zbusy"}, 32'(zbusy), 32'(0));
      chk({tag, " bcd"}, 32'(bcd), 32'(0));
      chk({tag, " d1"}, 32'(d1), 32'(7'h7F));
      chk({tag, " d2"}, 32'(d2), 32'(7'h7F));
      chk({tag, " d3"}, 32'(d3), 32'(7'h7F));
      chk({tag, " z1"}, 32'(z1), 32'(7'h7F));
      chk({tag, " z2"}, 32'(z2), 32'(7'h7F));
      chk({tag, " z3"}, 32'(z3), 32'(7'h7F));
   endtask

   task automatic check_bcd(input int v);
      chk($sformatf("bcd %0d", v), 32'(bcd), 32'(exp_bcd(v)));
      chk($sformatf("zbcd %0d", v), 32'(zbcd), 32'(exp_bcd(v)));
   endtask

   task automatic check_disp(input int v);
      logic [20:0] e, ez;
      e  = exp_disp(v, 1'b0, !show);
      ez = exp_disp(v, 1'b1, !show);
      chk($sformatf("d3 %0d", v), 32'(d3), 32'(e[20:14]));
      chk($sformatf("d2 %0d", v), 32'(d2), 32'(e[13:7]));
      chk($sformatf("d1 %0d", v), 32'(d1), 32'(e[6:0]));
      chk($sformatf("z3 %0d", v), 32'(z3), 32'(ez[20:14]));
      chk($sformatf("z2 %0d", v), 32'(z2), 32'(ez[13:7]));
      chk($sformatf("z1 %0d", v), 32'(z1), 32'(ez[6:0]));
   endtask

   // called right after edge DATA_W+1: result now, displays one edge later
   task automatic finish_conv();
      int v;
      if (q.size() == 0) begin
         chk("scoreboard empty", 32'(0), 32'(1));
         return;
      end
      v = q.pop_front();
      check_bcd(v);
      tick(1);
      check_disp(v);
   endtask

   // returns just after the edge that samples the load (edge 0)
   task automatic do_load(input int v);
      load    = 1'b1;
      data_in = 9'(v);
      q.push_back(v);
      tick(1);
      load = 1'b0;
   endtask

   initial begin
      n_reset = 1'b0;
      load    = 1'b0;
      data_in = '0;
      show    = 1'b1;
      tick(2);
      check_idle("in reset");
      n_reset = 1'b1;
      tick(6);
      check_idle("after reset");

      do_load(123);
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("busy 123 edge %0d", i), 32'(busy), 32'(1));
         tick(1);
      end
      chk("busy 123 end", 32'(busy), 32'(0));
      finish_conv();

      do_load(511);
      tick(10);
      finish_conv();

      do_load(0);
      tick(10);
      finish_conv();

      do_load(45);
      tick(2);
      load    = 1'b1;
      data_in = 9'd300;
      q.push_back(300);
      tick(1);
      load = 1'b0;
      tick(1);
      load    = 1'b1;
      data_in = 9'd7;
      q[q.size() - 1] = 7;
      tick(1);
      load = 1'b0;
      for (int i = 5; i < 10; i++) begin
         chk($sformatf("busy 45 edge %0d", i), 32'(busy), 32'(1));
         tick(1);
      end
      chk("busy pending edge 10", 32'(busy), 32'(1));
      finish_conv();
      for (int i = 11; i < 21; i++) begin
         chk($sformatf("busy 7 edge %0d", i), 32'(busy), 32'(1));
         tick(1);
      end
      chk("busy 7 end", 32'(busy), 32'(0));
      finish_conv();

      do_load(88);
      tick(3);
      show = 1'b0;
      tick(1);
      check_disp(0);
      tick(6);
      begin
         int v;
         v = q.pop_front();
         check_bcd(v);
         tick(1);
         check_disp(v);
         show = 1'b1;
         tick(1);
         check_disp(v);
      end

      do_load(200);
      tick(2);
      load    = 1'b1;
      data_in = 9'd99;
      tick(1);
      load = 1'b0;
      n_reset = 1'b0;
      #1;
      check_idle("async reset");
      q.delete();
      tick(1);
      n_reset = 1'b1;
      tick(14);
      check_idle("after abort");
      do_load(37);
      tick(10);
      finish_conv();

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule
